// File: rtl/kalman_pkg.sv
// kalman_pkg: shared state encoding, W-bit saturation and default constant-velocity A/Q tie-offs
package kalman_pkg;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_XHAT, S_AP, S_APAT, S_DONE} kp_state_t;

    function automatic logic signed [63:0] sat_w(input logic signed [127:0] v, input int w);
        logic signed [127:0] hi, lo;
        hi = (128'sd1 <<< (w - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (w - 1));
        return v > hi ? hi[63:0] : (v < lo ? lo[63:0] : v[63:0]);
    endfunction

    // 6-state Q20.12 layout [px, py, vx, vy, ax, ay]; dt = 0.1 couples each state to the one two ahead
    function automatic logic [1151:0] cv_matrix(input logic [31:0] diag, input logic [31:0] dt);
        logic [1151:0] m;
        m = '0;
        for (int r = 0; r < 6; r++) m[(r * 7) * 32 +: 32] = diag;
        for (int r = 0; r < 4; r++) m[(r * 7 + 2) * 32 +: 32] = dt;
        return m;
    endfunction

    localparam logic [1151:0] KP_DEFAULT_A = cv_matrix(32'd4096, 32'd410);
    localparam logic [1151:0] KP_DEFAULT_Q = cv_matrix(32'd41, 32'd0);
endpackage

// File: rtl/kp_mac_sat.sv
// kp_mac_sat: shared multiply-accumulate with fixed-point finish (shift, saturate, overflow flag)
// Build option: KALMAN_PREDICT_ROUND_EN rounds half up before the shift instead of truncating.
module kp_mac_sat #(
    parameter int W    = 32,
    parameter int FRAC = 12,
    parameter int AW   = 67
) (
    input  logic         clk,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] res,
    output logic         ovf
);
    import kalman_pkg::*;

`ifdef KALMAN_PREDICT_ROUND_EN
    localparam logic signed [AW:0] RND = (AW + 1)'(2 ** (FRAC - 1));
`else
    localparam logic signed [AW:0] RND = '0;
`endif

    logic signed [2*W-1:0] prod;
    logic signed [AW-1:0] acc, sum;
    logic signed [AW:0] rnd, shf;
    logic signed [63:0] clamp;

    // res is the finished value of the element including the current product
    assign prod  = (2 * W)'($signed(a)) * (2 * W)'($signed(b));
    assign sum   = (clr ? AW'(0) : acc) + AW'(prod);
    assign rnd   = (AW + 1)'(sum) + RND;
    assign shf   = rnd >>> FRAC;
    assign clamp = sat_w(128'(shf), W);
    assign res   = W'(clamp);
    assign ovf   = 128'(clamp) != 128'(shf);

    always_ff @(posedge clk) begin
        if (en) acc <= sum;
    end
endmodule

// File: rtl/kalman_predict_engine.sv
// kalman_predict_engine: time-multiplexed predict step, xhat = A*x and Phat = A*P*A' + Q, saturating.
// Build option: KALMAN_PREDICT_ROUND_EN (see kp_mac_sat) selects round-half-up in every MAC phase.
module kalman_predict_engine #(
    parameter int N    = 6,
    parameter int W    = 32,
    parameter int FRAC = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N*N*W-1:0] A_flat,
    input  logic [N*N*W-1:0] Q_flat,
    input  logic [N*N*W-1:0] P_flat,
    input  logic [N*W-1:0]   x_flat,
    output logic [N*W-1:0]   xhat_flat,
    output logic [N*N*W-1:0] Phat_flat,
    output logic             busy,
    output logic             done,
    output logic             overflow
);
    import kalman_pkg::*;

    localparam int IW = $clog2(N);
    localparam int AW = 2 * W + IW;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    kp_state_t state, state_n;
    logic [IW-1:0] i, j, k;
    logic signed [W-1:0] a_m [N][N];
    logic signed [W-1:0] q_m [N][N];
    logic signed [W-1:0] p_m [N][N];
    logic signed [W-1:0] t_m [N][N];
    logic signed [W-1:0] r_m [N][N];
    logic signed [W-1:0] x_m [N];
    logic signed [W-1:0] xh_m [N];
    logic signed [W-1:0] op_a, op_b, mac_res, q_res;
    logic signed [W:0] q_sum;
    logic signed [63:0] q_clamp;
    logic mac_en, mac_ovf, q_ovf, fin_ovf, last_k, last_j, last_i, phase_end, accept;

    kp_mac_sat #(.W(W), .FRAC(FRAC), .AW(AW)) u_mac (
        .clk(clk), .en(mac_en), .clr(k == '0), .a(op_a), .b(op_b), .res(mac_res), .ovf(mac_ovf)
    );

    // LOAD is the accepting edge itself: inputs are latched there and XHAT starts on the next edge
    always_comb begin
        accept    = state == S_IDLE && start;
        busy      = state != S_IDLE;
        mac_en    = state == S_XHAT || state == S_AP || state == S_APAT;
        last_k    = k == LAST;
        last_j    = state == S_XHAT || j == LAST;
        last_i    = i == LAST;
        phase_end = last_k && last_j && last_i;
        op_a      = state == S_APAT ? t_m[i][k] : a_m[i][k];
        op_b      = state == S_XHAT ? x_m[k] : (state == S_AP ? p_m[k][j] : a_m[j][k]);
        q_sum     = (W + 1)'(mac_res) + (W + 1)'(q_m[i][j]);
        q_clamp   = sat_w(128'(q_sum), W);
        q_res     = W'(q_clamp);
        q_ovf     = 128'(q_clamp) != 128'(q_sum);
        fin_ovf   = mac_ovf || (state == S_APAT && q_ovf);
        state_n   = state;
        case (state)
            S_IDLE:  if (start) state_n = S_XHAT;
            S_XHAT:  if (phase_end) state_n = S_AP;
            S_AP:    if (phase_end) state_n = S_APAT;
            S_APAT:  if (phase_end) state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            xhat_flat <= '0;
            Phat_flat <= '0;
        end else begin
            state <= state_n;
            done  <= state == S_DONE;
            if (accept) overflow <= 1'b0;
            else if (mac_en && last_k) overflow <= overflow | fin_ovf;
            if (mac_en) begin
                k <= last_k ? '0 : k + 1'b1;
                if (last_k) begin
                    j <= last_j ? '0 : j + 1'b1;
                    if (last_j) i <= last_i ? '0 : i + 1'b1;
                end
            end
            if (state == S_DONE) begin
                for (int r = 0; r < N; r++) begin
                    xhat_flat[r*W +: W] <= xh_m[r];
                    for (int c = 0; c < N; c++) Phat_flat[(r*N+c)*W +: W] <= r_m[r][c];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < N; r++) begin
                x_m[r] <= x_flat[r*W +: W];
                for (int c = 0; c < N; c++) begin
                    a_m[r][c] <= A_flat[(r*N+c)*W +: W];
                    q_m[r][c] <= Q_flat[(r*N+c)*W +: W];
                    p_m[r][c] <= P_flat[(r*N+c)*W +: W];
                end
            end
        end
        if (mac_en && last_k) begin
            if (state == S_XHAT) xh_m[i] <= mac_res;
            if (state == S_AP) t_m[i][j] <= mac_res;
            if (state == S_APAT) r_m[i][j] <= q_res;
        end
    end
endmodule
